ncc_scan_ctrl: RTL and testbench

Sequencer for the NCC window-match datapath. It loads a WIN_H x WIN_W pixel window from the byte stream into the per-row window BRAMs (one BRAM per window row, addressed by column). It then scans every candidate descriptor placement, issuing one column read per cycle to a DESC_H-row slice of those BRAMs, with the tags the correlation accumulator needs. It sits between the PCI byte input and the row-BRAM/accumulator datapath, beside the descriptor loader.

---
 rtl/ncc_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ncc_scan_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncc_scan_ctrl.sv
// ncc_scan_ctrl
// Sequencer for the NCC window-match datapath. It streams a WIN_H x WIN_W
// pixel window into the per-row BRAMs. It then walks every descriptor
// placement, issuing one column read per cycle to the accumulator.
// Optional feature macro: NCC_SCAN_STALL_CNT_EN adds the stall_cnt output.
module ncc_scan_ctrl #(
  parameter int WIN_W  = 80,
  parameter int WIN_H  = 16,
  parameter int DESC_W = 16,
  parameter int DESC_H = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      skip_load,
  input  logic                      pix_valid,
  input  logic [7:0]                pix_data,
  output logic                      pix_ready,
  output logic                      wr_en,
  output logic [$clog2(WIN_H)-1:0]  wr_row,
  output logic [$clog2(WIN_W)-1:0]  wr_col,
  output logic [7:0]                wr_data,
  input  logic                      acc_ready,
  output logic                      rd_en,
  output logic [$clog2(WIN_W)-1:0]  rd_col,
  output logic [$clog2(WIN_H)-1:0]  rd_row_base,
  output logic [$clog2(DESC_W)-1:0] desc_col,
  output logic [$clog2(WIN_W)-1:0]  pos_x,
  output logic [$clog2(WIN_H)-1:0]  pos_y,
  output logic                      pos_first,
  output logic                      pos_last,
  output logic                      busy,
  output logic                      done
`ifdef NCC_SCAN_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int WW = $clog2(WIN_W);
  localparam int HW = $clog2(WIN_H);
  localparam int CW = $clog2(DESC_W);

  localparam logic [WW-1:0] COL_LAST = WW'(WIN_W - 1);
  localparam logic [HW-1:0] ROW_LAST = HW'(WIN_H - 1);
  localparam logic [CW-1:0] C_LAST   = CW'(DESC_W - 1);
  localparam logic [WW-1:0] X_LAST   = WW'(WIN_W - DESC_W);
  localparam logic [HW-1:0] Y_LAST   = HW'(WIN_H - DESC_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt;
  logic [HW-1:0]   row_r;
  logic [WW-1:0]   col_r;
  logic [CW-1:0]   c_r;
  logic [WW-1:0]   x_r;
  logic [HW-1:0]   y_r;
  logic            load_last;
  logic            scan_last;

  assign load_last = pix_valid && (row_r == ROW_LAST) && (col_r == COL_LAST);
  assign scan_last = acc_ready && (c_r == C_LAST) && (x_r == X_LAST) && (y_r == Y_LAST);

  // Next-state decode and combinational outputs driven from the counters.
  always_comb begin
    state_nxt   = state_r;
    pix_ready   = 1'b0;
    wr_en       = 1'b0;
    wr_row      = row_r;
    wr_col      = col_r;
    wr_data     = pix_data;
    rd_en       = 1'b0;
    rd_col      = x_r + WW'(c_r);
    rd_row_base = y_r;
    desc_col    = c_r;
    pos_x       = x_r;
    pos_y       = y_r;
    pos_first   = 1'b0;
    pos_last    = 1'b0;
    done        = 1'b0;
    busy        = (state_r != IDLE);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt = skip_load ? SCAN : LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        pix_ready = 1'b1;
        wr_en     = pix_valid;
        if (load_last) begin
          state_nxt = SCAN;
        end else begin
          state_nxt = LOAD;
        end
      end
      SCAN: begin
        rd_en     = acc_ready;
        pos_first = acc_ready && (c_r == '0);
        pos_last  = acc_ready && (c_r == C_LAST);
        if (scan_last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SCAN;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; a synchronous reset aborts any job immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Load raster counters and scan placement counters (c fastest, then x, then y).
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r <= '0;
      col_r <= '0;
      c_r   <= '0;
      x_r   <= '0;
      y_r   <= '0;
    end else begin
      case (state_r)
        LOAD: begin
          if (pix_valid) begin
            if (col_r == COL_LAST) begin
              col_r <= '0;
              row_r <= (row_r == ROW_LAST) ? '0 : row_r + 1'b1;
            end else begin
              col_r <= col_r + 1'b1;
            end
          end
        end
        SCAN: begin
          if (acc_ready) begin
            if (c_r == C_LAST) begin
              c_r <= '0;
              if (x_r == X_LAST) begin
                x_r <= '0;
                y_r <= (y_r == Y_LAST) ? '0 : y_r + 1'b1;
              end else begin
                x_r <= x_r + 1'b1;
              end
            end else begin
              c_r <= c_r + 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE park every counter at zero so each job starts clean.
          row_r <= '0;
          col_r <= '0;
          c_r   <= '0;
          x_r   <= '0;
          y_r   <= '0;
        end
      endcase
    end
  end

`ifdef NCC_SCAN_STALL_CNT_EN
  // Saturating count of SCAN cycles lost to accumulator back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if ((state_r == IDLE) && start) begin
      stall_cnt <= 32'd0;
    end else if ((state_r == SCAN) && !acc_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ncc_scan_ctrl.sv
// Testbench for ncc_scan_ctrl: a beat-index model checked every cycle for the
// default-size instance, plus directed checks on a 20x18 instance.
`timescale 1ns/1ps
module tb_ncc_scan_ctrl;
  localparam int WW = 80, WH = 16, DW = 16, DH = 16;
  localparam int NX = WW - DW + 1;
  localparam int NY = WH - DH + 1;
  localparam int NLOAD = WW * WH;
  localparam int NSCAN = DW * NX * NY;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, skip_load = 1'b0, pix_valid = 1'b0, acc_ready = 1'b0;
  logic [7:0] pix_data = 8'd0;
  logic pix_ready, wr_en, rd_en, pos_first, pos_last, busy, done;
  logic [3:0] wr_row, rd_row_base, pos_y, desc_col;
  logic [6:0] wr_col, rd_col, pos_x;
  logic [7:0] wr_data;
`ifdef NCC_SCAN_STALL_CNT_EN
  logic [31:0] stall_cnt, s_stall_cnt;
`endif

  logic s_rst = 1'b1, s_start = 1'b0, s_skip = 1'b0, s_acc_ready = 1'b0;
  logic s_pix_ready, s_wr_en, s_rd_en, s_pos_first, s_pos_last, s_busy, s_done;
  logic [4:0] s_wr_row, s_wr_col, s_rd_col, s_rd_row_base, s_pos_x, s_pos_y;
  logic [3:0] s_desc_col;
  logic [7:0] s_wr_data;

  always #5 clk = ~clk;

  ncc_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .skip_load(skip_load),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .acc_ready(acc_ready), .rd_en(rd_en), .rd_col(rd_col), .rd_row_base(rd_row_base),
    .desc_col(desc_col), .pos_x(pos_x), .pos_y(pos_y), .pos_first(pos_first),
    .pos_last(pos_last), .busy(busy), .done(done)
`ifdef NCC_SCAN_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  ncc_scan_ctrl #(.WIN_W(20), .WIN_H(18), .DESC_W(16), .DESC_H(16)) dut_s (
    .clk(clk), .rst(s_rst), .start(s_start), .skip_load(s_skip),
    .pix_valid(1'b0), .pix_data(8'h00), .pix_ready(s_pix_ready),
    .wr_en(s_wr_en), .wr_row(s_wr_row), .wr_col(s_wr_col), .wr_data(s_wr_data),
    .acc_ready(s_acc_ready), .rd_en(s_rd_en), .rd_col(s_rd_col), .rd_row_base(s_rd_row_base),
    .desc_col(s_desc_col), .pos_x(s_pos_x), .pos_y(s_pos_y), .pos_first(s_pos_first),
    .pos_last(s_pos_last), .busy(s_busy), .done(s_done)
`ifdef NCC_SCAN_STALL_CNT_EN
    , .stall_cnt(s_stall_cnt)
`endif
  );

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase plus linear beat indices; coordinates derived by div/mod.
  int m_phase = 0, m_lidx = 0, m_sidx = 0;
  logic [31:0] m_stall = 32'd0;
  int wr_beats = 0, rd_beats = 0, dones = 0;
  int last_px = 0, last_rc = 0, last_pl = 0;

  // Per-cycle compare of the default instance against the model, then model step.
  always @(negedge clk) begin : cmp
    int c, x, y;
    logic e_wr, e_rd;
    if (chk_en) begin
      e_wr = (m_phase == 1) && pix_valid;
      e_rd = (m_phase == 2) && acc_ready;
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_phase == 3);
      chk("pix_ready", pix_ready, m_phase == 1);
      chk("wr_en", wr_en, e_wr);
      chk("rd_en", rd_en, e_rd);
      if (e_wr) begin
        chk("wr_row", wr_row, m_lidx / WW);
        chk("wr_col", wr_col, m_lidx % WW);
        chk("wr_data", wr_data, pix_data);
      end
      if (m_phase == 2) begin
        c = m_sidx % DW;
        x = (m_sidx / DW) % NX;
        y = m_sidx / (DW * NX);
        chk("rd_col", rd_col, x + c);
        chk("pos_x", pos_x, x);
        chk("pos_y", pos_y, y);
        chk("rd_row_base", rd_row_base, y);
        chk("desc_col", desc_col, c);
        chk("pos_first", pos_first, e_rd && (c == 0));
        chk("pos_last", pos_last, e_rd && (c == DW - 1));
      end else begin
        chk("pos_first_idle", pos_first, 1'b0);
        chk("pos_last_idle", pos_last, 1'b0);
      end
`ifdef NCC_SCAN_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
      if (wr_en === 1'b1) wr_beats++;
      if (rd_en === 1'b1) begin
        rd_beats++;
        last_px = int'(pos_x);
        last_rc = int'(rd_col);
        last_pl = int'(pos_last);
      end
      if (done === 1'b1) dones++;
      if (rst) begin
        m_phase = 0; m_lidx = 0; m_sidx = 0; m_stall = 32'd0;
      end else begin
        case (m_phase)
          0: if (start) begin
               m_phase = skip_load ? 2 : 1;
               m_lidx = 0; m_sidx = 0; m_stall = 32'd0;
             end
          1: if (pix_valid) begin
               m_lidx++;
               if (m_lidx == NLOAD) begin m_phase = 2; m_lidx = 0; end
             end
          2: if (acc_ready) begin
               m_sidx++;
               if (m_sidx == NSCAN) m_phase = 3;
             end else if (m_stall != 32'hFFFF_FFFF) begin
               m_stall = m_stall + 32'd1;
             end
          3: m_phase = 0;
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Collects placement order and beat counts from the 20x18 instance.
  int s_rd = 0, s_first = 0, s_last = 0, s_dones = 0;
  int s_q[$];
  always @(negedge clk) begin
    if (s_rd_en === 1'b1) s_rd++;
    if (s_rd_en === 1'b1 && s_pos_first === 1'b1) begin
      s_first++;
      s_q.push_back(int'(s_pos_y) * 256 + int'(s_pos_x));
    end
    if (s_rd_en === 1'b1 && s_pos_last === 1'b1) s_last++;
    if (s_done === 1'b1) s_dones++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic skip);
    start = 1'b1; skip_load = skip;
    tick();
    start = 1'b0; skip_load = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int lim);
    for (int k = 0; k < lim && dones == d0; k++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, r0, issued, stalled;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; s_rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 32'd0);
    chk("rst_rd_en", rd_en, 32'd0);
    chk("rst_wr_en", wr_en, 32'd0);
    chk("rst_pix_ready", pix_ready, 32'd0);
    chk("rst_done", done, 32'd0);
    tick();

    // Full load then full scan, with stray start pulses in LOAD and SCAN
    d0 = dones; w0 = wr_beats; r0 = rd_beats;
    acc_ready = 1'b0;
    do_start(1'b0);
    for (int i = 0; i < NLOAD; i++) begin
      pix_valid = 1'b1; pix_data = 8'(i * 7 + 3);
      start = (i == 300);
      tick();
    end
    pix_valid = 1'b0; start = 1'b0; acc_ready = 1'b1;
    for (int k = 0; k < 3000 && dones == d0; k++) begin
      start = (k == 500);
      tick();
    end
    start = 1'b0;
    @(negedge clk);
    chk("t1_busy_after", busy, 32'd0);
    tick(); tick(); tick();
    chk("t1_writes", wr_beats - w0, 32'd1280);
    chk("t1_reads", rd_beats - r0, 32'd1040);
    chk("t1_dones", dones - d0, 32'd1);
    chk("t1_last_pos_x", last_px, 32'd64);
    chk("t1_last_rd_col", last_rc, 32'd79);
    chk("t1_last_pos_last", last_pl, 32'd1);

    // pix_valid toggling during LOAD
    d0 = dones; w0 = wr_beats; r0 = rd_beats;
    acc_ready = 1'b0;
    do_start(1'b0);
    for (int i = 0; i < 2 * NLOAD; i++) begin
      pix_valid = (i % 2 == 0); pix_data = 8'(i);
      tick();
    end
    pix_valid = 1'b0;
    chk("t2_writes", wr_beats - w0, 32'd1280);
    acc_ready = 1'b1;
    wait_done(d0, 3000);
    chk("t2_reads", rd_beats - r0, 32'd1040);
    chk("t2_dones", dones - d0, 32'd1);

    // Small window: 15 placements in raster order
    s_acc_ready = 1'b1; s_start = 1'b1; s_skip = 1'b1;
    tick();
    s_start = 1'b0; s_skip = 1'b0;
    for (int k = 0; k < 1000 && s_dones == 0; k++) tick();
    tick();
    chk("s_reads", s_rd, 32'd240);
    chk("s_first", s_first, 32'd15);
    chk("s_last", s_last, 32'd15);
    chk("s_dones", s_dones, 32'd1);
    chk("s_order_len", s_q.size(), 32'd15);
    for (int k = 0; k < s_q.size(); k++)
      chk("s_order", s_q[k], (k / 5) * 256 + (k % 5));

    // Back-pressure: 10 stall cycles at beat c=7 of x=3
    d0 = dones; r0 = rd_beats; issued = 0; stalled = 0;
    do_start(1'b1);
    for (int k = 0; k < 3000 && issued < NSCAN; k++) begin
      if (issued == 55 && stalled < 10) begin
        acc_ready = 1'b0; stalled++;
        @(negedge clk);
        chk("stall_pos_x", pos_x, 32'd3);
        chk("stall_desc_col", desc_col, 32'd7);
        chk("stall_rd_col", rd_col, 32'd10);
        chk("stall_rd_en", rd_en, 32'd0);
        tick();
      end else begin
        acc_ready = 1'b1; issued++;
        tick();
      end
    end
    acc_ready = 1'b1;
    wait_done(d0, 20);
    tick();
    chk("t4_reads", rd_beats - r0, 32'd1040);
    chk("t4_dones", dones - d0, 32'd1);
`ifdef NCC_SCAN_STALL_CNT_EN
    chk("t4_stall_cnt", stall_cnt, 32'd10);
`endif

    // Reset at scan beat 500, then restart from the origin
    d0 = dones;
    acc_ready = 1'b1;
    do_start(1'b1);
    repeat (500) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", busy, 32'd0);
    chk("t5_rd_en", rd_en, 32'd0);
    tick(); tick();
    chk("t5_no_done", dones - d0, 32'd0);
    do_start(1'b1);
    @(negedge clk);
    chk("t5_restart_x", pos_x, 32'd0);
    chk("t5_restart_y", pos_y, 32'd0);
    chk("t5_restart_c", desc_col, 32'd0);
    chk("t5_restart_first", pos_first, 32'd1);
    tick();
    wait_done(d0, 3000);
    tick();
    chk("t5_dones", dones - d0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
